// File: rtl/axi_lite_pkg.sv
// Shared types and helpers for the AXI4-Lite register block.
package axi_lite_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        W_IDLE,
        W_HAVE_ADDR,
        W_HAVE_DATA,
        W_RESP
    } wr_state_t;

    typedef enum logic {
        R_IDLE,
        R_RESP
    } rd_state_t;

    // Byte lanes with strb set take the new byte, the rest keep the old one.
    function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                                input logic [31:0] new_word,
                                                input logic [3:0]  strb);
        logic [31:0] merged;
        merged = old_word;
        for (int k = 0; k < 4; k++) begin
            if (strb[k]) merged[8*k +: 8] = new_word[8*k +: 8];
        end
        return merged;
    endfunction

endpackage

// File: rtl/axi_lite_regs.sv
// AXI4-Lite responder: NUM_RW control registers followed by NUM_RO status words.
// Independent write and read channels, one outstanding transaction each.
module axi_lite_regs
    import axi_lite_pkg::*;
#(
    parameter int unsigned NUM_RW     = 8,
    parameter int unsigned NUM_RO     = 4,
    parameter int unsigned ADDR_WIDTH = 12
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [31:0]            AWADDR,
    input  logic [2:0]             AWPROT,
    input  logic                   AWVALID,
    output logic                   AWREADY,
    input  logic [31:0]            WDATA,
    input  logic [3:0]             WSTRB,
    input  logic                   WVALID,
    output logic                   WREADY,
    output logic [1:0]             BRESP,
    output logic                   BVALID,
    input  logic                   BREADY,
    input  logic [31:0]            ARADDR,
    input  logic [2:0]             ARPROT,
    input  logic                   ARVALID,
    output logic                   ARREADY,
    output logic [31:0]            RDATA,
    output logic [1:0]             RRESP,
    output logic                   RVALID,
    input  logic                   RREADY,
    output logic [32*NUM_RW-1:0]   ctrl_o,
    output logic [NUM_RW-1:0]      wr_pulse_o,
    input  logic [32*NUM_RO-1:0]   status_i
);

    localparam int unsigned IDX_W = ADDR_WIDTH - 2;
    localparam logic [IDX_W-1:0] RW_END = IDX_W'(NUM_RW);
    localparam logic [IDX_W-1:0] RO_END = IDX_W'(NUM_RW + NUM_RO);

    wr_state_t        r_wstate, w_wstate_d;
    rd_state_t        r_rstate, w_rstate_d;
    logic [IDX_W-1:0] r_awidx;
    logic [31:0]      r_wdata;
    logic [3:0]       r_wstrb;
    logic             r_awready, r_wready, r_arready;
    logic [1:0]       r_bresp, r_rresp;
    logic [31:0]      r_rdata;
    logic [31:0]      r_ctrl [NUM_RW];
    logic [NUM_RW-1:0] r_wr_pulse;

    logic             w_aw_hs, w_w_hs, w_ar_hs, w_commit;
    logic [IDX_W-1:0] w_cm_idx, w_ar_idx;
    logic [31:0]      w_cm_data, w_rd_data;
    logic [3:0]       w_cm_strb;
    logic [1:0]       w_rd_resp;
    logic             w_unused;

    // Protection bits, byte offset and upper address bits carry no meaning here.
    assign w_unused = ^{AWPROT, ARPROT, AWADDR[31:ADDR_WIDTH], AWADDR[1:0],
                        ARADDR[31:ADDR_WIDTH], ARADDR[1:0]};

    assign w_aw_hs  = AWVALID & r_awready;
    assign w_w_hs   = WVALID & r_wready;
    assign w_ar_hs  = ARVALID & r_arready;
    assign w_ar_idx = ARADDR[ADDR_WIDTH-1:2];

    // Commit operands come from the holding register or straight from the bus.
    assign w_cm_idx  = (r_wstate == W_HAVE_ADDR) ? r_awidx : AWADDR[ADDR_WIDTH-1:2];
    assign w_cm_data = (r_wstate == W_HAVE_DATA) ? r_wdata : WDATA;
    assign w_cm_strb = (r_wstate == W_HAVE_DATA) ? r_wstrb : WSTRB;

    // Write FSM next state and commit strobe.
    always_comb begin
        w_wstate_d = r_wstate;
        w_commit   = 1'b0;
        case (r_wstate)
            W_IDLE: begin
                if (w_aw_hs && w_w_hs) begin
                    w_wstate_d = W_RESP;
                    w_commit   = 1'b1;
                end else if (w_aw_hs) begin
                    w_wstate_d = W_HAVE_ADDR;
                end else if (w_w_hs) begin
                    w_wstate_d = W_HAVE_DATA;
                end
            end
            W_HAVE_ADDR: begin
                if (w_w_hs) begin
                    w_wstate_d = W_RESP;
                    w_commit   = 1'b1;
                end
            end
            W_HAVE_DATA: begin
                if (w_aw_hs) begin
                    w_wstate_d = W_RESP;
                    w_commit   = 1'b1;
                end
            end
            W_RESP: begin
                if (BREADY) w_wstate_d = W_IDLE;
            end
            default: w_wstate_d = W_IDLE;
        endcase
    end

    // Read FSM next state and response lookup.
    always_comb begin
        w_rstate_d = r_rstate;
        w_rd_data  = '0;
        w_rd_resp  = RESP_SLVERR;
        case (r_rstate)
            R_IDLE:  if (w_ar_hs) w_rstate_d = R_RESP;
            R_RESP:  if (RREADY) w_rstate_d = R_IDLE;
            default: w_rstate_d = R_IDLE;
        endcase
        if (w_ar_idx < RW_END) begin
            w_rd_resp = RESP_OKAY;
            for (int i = 0; i < NUM_RW; i++) begin
                if (w_ar_idx == IDX_W'(i)) w_rd_data = r_ctrl[i];
            end
        end else if (w_ar_idx < RO_END) begin
            w_rd_resp = RESP_OKAY;
            for (int j = 0; j < NUM_RO; j++) begin
                if (w_ar_idx == IDX_W'(NUM_RW + j)) w_rd_data = status_i[32*j +: 32];
            end
        end
    end

    // State, ready flags and response registers; readies follow the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wstate  <= W_IDLE;
            r_rstate  <= R_IDLE;
            r_awready <= 1'b0;
            r_wready  <= 1'b0;
            r_arready <= 1'b0;
            r_bresp   <= RESP_OKAY;
            r_rresp   <= RESP_OKAY;
            r_rdata   <= '0;
        end else begin
            r_wstate  <= w_wstate_d;
            r_rstate  <= w_rstate_d;
            r_awready <= (w_wstate_d == W_IDLE) || (w_wstate_d == W_HAVE_DATA);
            r_wready  <= (w_wstate_d == W_IDLE) || (w_wstate_d == W_HAVE_ADDR);
            r_arready <= (w_rstate_d == R_IDLE);
            if (w_commit) r_bresp <= (w_cm_idx < RW_END) ? RESP_OKAY : RESP_SLVERR;
            if (w_ar_hs) begin
                r_rdata <= w_rd_data;
                r_rresp <= w_rd_resp;
            end
        end
    end

    // Holding registers for whichever of AW/W arrives first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_awidx <= '0;
            r_wdata <= '0;
            r_wstrb <= '0;
        end else begin
            if (w_aw_hs) r_awidx <= AWADDR[ADDR_WIDTH-1:2];
            if (w_w_hs) begin
                r_wdata <= WDATA;
                r_wstrb <= WSTRB;
            end
        end
    end

    // Control register update and per-register write strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_RW; i++) r_ctrl[i] <= '0;
            r_wr_pulse <= '0;
        end else begin
            for (int i = 0; i < NUM_RW; i++) begin
                r_wr_pulse[i] <= 1'b0;
                if (w_commit && (w_cm_idx == IDX_W'(i))) begin
                    r_ctrl[i]     <= merge_bytes(r_ctrl[i], w_cm_data, w_cm_strb);
                    r_wr_pulse[i] <= |w_cm_strb;
                end
            end
        end
    end

    // Flatten the control array onto the output bus.
    always_comb begin
        ctrl_o = '0;
        for (int i = 0; i < NUM_RW; i++) ctrl_o[32*i +: 32] = r_ctrl[i];
    end

    assign AWREADY    = r_awready;
    assign WREADY     = r_wready;
    assign ARREADY    = r_arready;
    assign BVALID     = (r_wstate == W_RESP);
    assign BRESP      = r_bresp;
    assign RVALID     = (r_rstate == R_RESP);
    assign RDATA      = r_rdata;
    assign RRESP      = r_rresp;
    assign wr_pulse_o = r_wr_pulse;

endmodule

// File: tb/tb_axi_lite_regs.sv
// Directed self-checking bench for axi_lite_regs.
module tb_axi_lite_regs;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [31:0]  AWADDR, WDATA, ARADDR, RDATA;
    logic [2:0]   AWPROT, ARPROT;
    logic         AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
    logic         ARVALID, ARREADY, RVALID, RREADY;
    logic [3:0]   WSTRB;
    logic [1:0]   BRESP, RRESP;
    logic [255:0] ctrl_o;
    logic [7:0]   wr_pulse_o;
    logic [127:0] status_i;

    logic [255:0] exp_ctrl;
    int           n_checks = 0;
    int           n_errors = 0;

    always #5 clk = ~clk;

    axi_lite_regs #(
        .NUM_RW     (8),
        .NUM_RO     (4),
        .ADDR_WIDTH (12)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .AWADDR     (AWADDR),
        .AWPROT     (AWPROT),
        .AWVALID    (AWVALID),
        .AWREADY    (AWREADY),
        .WDATA      (WDATA),
        .WSTRB      (WSTRB),
        .WVALID     (WVALID),
        .WREADY     (WREADY),
        .BRESP      (BRESP),
        .BVALID     (BVALID),
        .BREADY     (BREADY),
        .ARADDR     (ARADDR),
        .ARPROT     (ARPROT),
        .ARVALID    (ARVALID),
        .ARREADY    (ARREADY),
        .RDATA      (RDATA),
        .RRESP      (RRESP),
        .RVALID     (RVALID),
        .RREADY     (RREADY),
        .ctrl_o     (ctrl_o),
        .wr_pulse_o (wr_pulse_o),
        .status_i   (status_i)
    );

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // AW and W presented together with BREADY high.
    task automatic write_both(input logic [31:0] addr, input logic [31:0] data,
                              input logic [3:0] strb, input logic [1:0] exp_resp,
                              input logic [7:0] exp_pulse, input string tag);
        AWADDR  = addr;
        WDATA   = data;
        WSTRB   = strb;
        AWVALID = 1'b1;
        WVALID  = 1'b1;
        BREADY  = 1'b1;
        step();
        AWVALID = 1'b0;
        WVALID  = 1'b0;
        chk({tag, " bvalid"}, 256'(BVALID), 256'(1));
        chk({tag, " bresp"}, 256'(BRESP), 256'(exp_resp));
        chk({tag, " ctrl"}, ctrl_o, exp_ctrl);
        chk({tag, " pulse"}, 256'(wr_pulse_o), 256'(exp_pulse));
        step();
        chk({tag, " bvalid drop"}, 256'(BVALID), 256'(0));
        chk({tag, " pulse drop"}, 256'(wr_pulse_o), 256'(0));
    endtask

    task automatic do_read(input logic [31:0] addr, input logic [31:0] exp_data,
                           input logic [1:0] exp_resp, input string tag);
        ARADDR  = addr;
        ARVALID = 1'b1;
        RREADY  = 1'b1;
        step();
        ARVALID = 1'b0;
        chk({tag, " rvalid"}, 256'(RVALID), 256'(1));
        chk({tag, " rdata"}, 256'(RDATA), 256'(exp_data));
        chk({tag, " rresp"}, 256'(RRESP), 256'(exp_resp));
        step();
        chk({tag, " rvalid drop"}, 256'(RVALID), 256'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL timeout got running expected finished");
        $fatal(1);
    end

    initial begin
        rst_n    = 1'b1;
        AWADDR   = '0;
        AWPROT   = '0;
        AWVALID  = 1'b0;
        WDATA    = '0;
        WSTRB    = '0;
        WVALID   = 1'b0;
        BREADY   = 1'b0;
        ARADDR   = '0;
        ARPROT   = '0;
        ARVALID  = 1'b0;
        RREADY   = 1'b0;
        status_i = '0;
        status_i[31:0]   = 32'hCAFE_0001;
        status_i[127:96] = 32'hDEAD_BEEF;
        exp_ctrl = '0;

        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst awready", 256'(AWREADY), 256'(0));
        chk("rst wready", 256'(WREADY), 256'(0));
        chk("rst arready", 256'(ARREADY), 256'(0));
        chk("rst bvalid", 256'(BVALID), 256'(0));
        chk("rst rvalid", 256'(RVALID), 256'(0));
        chk("rst bresp/rresp", 256'({BRESP, RRESP}), 256'(0));
        chk("rst rdata", 256'(RDATA), 256'(0));
        chk("rst ctrl", ctrl_o, 256'(0));
        chk("rst pulse", 256'(wr_pulse_o), 256'(0));
        rst_n = 1'b1;
        step();
        chk("post-rst readies", 256'({AWREADY, WREADY, ARREADY}), 256'(3'b111));

        // Full-word write to word 1 and read back.
        exp_ctrl[63:32] = 32'hA5A5_1234;
        write_both(32'h4, 32'hA5A5_1234, 4'hF, 2'b00, 8'h02, "wr1");
        do_read(32'h4, 32'hA5A5_1234, 2'b00, "rd1");

        // Data three cycles ahead of the address, one byte lane enabled.
        WDATA  = 32'hFFFF_FFFF;
        WSTRB  = 4'b0010;
        WVALID = 1'b1;
        BREADY = 1'b1;
        step();
        WVALID = 1'b0;
        chk("wfirst wready drop", 256'(WREADY), 256'(0));
        chk("wfirst awready", 256'(AWREADY), 256'(1));
        step();
        step();
        chk("wfirst no bvalid", 256'(BVALID), 256'(0));
        chk("wfirst ctrl held", ctrl_o, exp_ctrl);
        AWADDR  = 32'h4;
        AWVALID = 1'b1;
        step();
        AWVALID = 1'b0;
        exp_ctrl[63:32] = 32'hA5A5_FF34;
        chk("wfirst bvalid", 256'(BVALID), 256'(1));
        chk("wfirst bresp", 256'(BRESP), 256'(0));
        chk("wfirst ctrl", ctrl_o, exp_ctrl);
        chk("wfirst pulse", 256'(wr_pulse_o), 256'(8'h02));
        step();
        chk("wfirst bvalid drop", 256'(BVALID), 256'(0));

        // Status and out-of-range targets, address aliasing above bit 11.
        write_both(32'h20, 32'h1234_5678, 4'hF, 2'b10, 8'h00, "wr ro");
        write_both(32'h40, 32'h1234_5678, 4'hF, 2'b10, 8'h00, "wr oor");
        write_both(32'h0, 32'hFFFF_FFFF, 4'h0, 2'b00, 8'h00, "wr strb0");
        do_read(32'h20, 32'hCAFE_0001, 2'b00, "rd ro0");
        do_read(32'h2C, 32'hDEAD_BEEF, 2'b00, "rd ro3");
        do_read(32'h40, 32'h0, 2'b10, "rd oor");
        do_read(32'h1004, 32'hA5A5_FF34, 2'b00, "rd alias");

        // Same-edge read and write of word 1 under response backpressure.
        AWADDR  = 32'h4;
        WDATA   = 32'h1111_2222;
        WSTRB   = 4'hF;
        ARADDR  = 32'h4;
        AWVALID = 1'b1;
        WVALID  = 1'b1;
        ARVALID = 1'b1;
        BREADY  = 1'b0;
        RREADY  = 1'b0;
        step();
        AWVALID = 1'b0;
        WVALID  = 1'b0;
        ARVALID = 1'b0;
        exp_ctrl[63:32] = 32'h1111_2222;
        chk("bp pulse", 256'(wr_pulse_o), 256'(8'h02));
        for (int c = 0; c < 5; c++) begin
            chk("bp bvalid", 256'(BVALID), 256'(1));
            chk("bp bresp", 256'(BRESP), 256'(0));
            chk("bp rvalid", 256'(RVALID), 256'(1));
            chk("bp rdata pre-write", 256'(RDATA), 256'(32'hA5A5_FF34));
            chk("bp rresp", 256'(RRESP), 256'(0));
            chk("bp readies low", 256'({AWREADY, WREADY, ARREADY}), 256'(0));
            chk("bp ctrl", ctrl_o, exp_ctrl);
            step();
        end
        chk("bp pulse single", 256'(wr_pulse_o), 256'(0));
        BREADY = 1'b1;
        RREADY = 1'b1;
        step();
        chk("bp bvalid drop", 256'(BVALID), 256'(0));
        chk("bp rvalid drop", 256'(RVALID), 256'(0));
        chk("bp readies back", 256'({AWREADY, WREADY, ARREADY}), 256'(3'b111));

        // Reset between the address and data handshakes.
        AWADDR  = 32'hC;
        AWVALID = 1'b1;
        step();
        AWVALID = 1'b0;
        chk("mid awready", 256'(AWREADY), 256'(0));
        chk("mid wready", 256'(WREADY), 256'(1));
        rst_n = 1'b0;
        #1;
        exp_ctrl = '0;
        chk("mid rst readies", 256'({AWREADY, WREADY, ARREADY}), 256'(0));
        chk("mid rst valids", 256'({BVALID, RVALID}), 256'(0));
        chk("mid rst ctrl", ctrl_o, exp_ctrl);
        chk("mid rst pulse", 256'(wr_pulse_o), 256'(0));
        step();
        rst_n = 1'b1;
        step();
        chk("mid post readies", 256'({AWREADY, WREADY, ARREADY}), 256'(3'b111));
        WDATA  = 32'h5555_AAAA;
        WSTRB  = 4'hF;
        WVALID = 1'b1;
        step();
        WVALID = 1'b0;
        step();
        chk("mid no stale commit", 256'(BVALID), 256'(0));
        chk("mid ctrl zero", ctrl_o, exp_ctrl);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/axi_lite_regs.md
# axi_lite_regs

AXI4-Lite responder exposing a block of 32-bit control/status registers to the PS. It sits behind the AXI interconnect as the endpoint the testbench AXI-Lite driver talks to. It provides NUM_RW read/write control registers that drive fabric logic and NUM_RO read-only status registers sampled from fabric logic. It supports one outstanding write and one outstanding read, handled by independent channels.

## Interface
- NUM_RW, 8: number of read/write control registers, word index 0..NUM_RW-1.
- NUM_RO, 4: number of read-only status registers, word index NUM_RW..NUM_RW+NUM_RO-1.
- ADDR_WIDTH, 12: decoded address bits; AWADDR/ARADDR bits above this are ignored.
- clk  in  1  single clock for all logic.
- rst_n  in  1  asynchronous, active-low reset.
- AWADDR, AWPROT, AWVALID / AWREADY  in,in,in / out  32,3,1 / 1  write address channel; AWPROT ignored.
- WDATA, WSTRB, WVALID / WREADY  in,in,in / out  32,4,1 / 1  write data channel.
- BRESP, BVALID / BREADY  out,out / in  2,1 / 1  write response channel.
- ARADDR, ARPROT, ARVALID / ARREADY  in,in,in / out  32,3,1 / 1  read address channel; ARPROT ignored.
- RDATA, RRESP, RVALID / RREADY  out,out,out / in  32,2,1 / 1  read data channel.
- ctrl_o  out  32*NUM_RW  control register contents, register i at bits [32i+31:32i].
- wr_pulse_o  out  NUM_RW  one-cycle strobe on the cycle after register i is written with OKAY.
- status_i  in  32*NUM_RO  status inputs, status j at bits [32j+31:32j].

## Operation
- Word index = ADDR[ADDR_WIDTH-1:2]; ADDR[1:0] ignored.
- Write FSM: W_IDLE -> W_HAVE_ADDR / W_HAVE_DATA -> W_RESP -> W_IDLE.
  - AW and W may arrive in either order or on the same edge. Each is captured into its own holding register.
  - AWREADY is high only while the address is not yet held and state != W_RESP. WREADY follows the same rule for data.
  - Commit happens on the edge where the second of AW/W handshakes, or on the edge where both handshake together. On that edge the FSM enters W_RESP with BVALID=1.
- Write decode:
  - RW index: byte lanes with WSTRB[k]=1 take WDATA[8k+7:8k]; the other lanes keep their old value. BRESP=OKAY (2'b00).
  - WSTRB=0 on an RW index: no change, OKAY, no wr_pulse_o.
  - RO index or out-of-range index: no register change, BRESP=SLVERR (2'b10).
- Read FSM: R_IDLE -> R_RESP -> R_IDLE. ARREADY=1 in R_IDLE only.
  - On the AR handshake edge, RDATA and RRESP are registered and RVALID=1.
  - RW index: RDATA = ctrl register, OKAY.
  - RO index: RDATA = status_i word sampled on the handshake edge, OKAY.
  - Out-of-range index: RDATA=0, SLVERR.
- Read and write channels are fully independent and may complete on the same cycle.
- Read and write to the same register on the same edge: the read returns the pre-write value.

## Timing
- Reset values: AWREADY=WREADY=ARREADY=0, BVALID=RVALID=0, BRESP=RRESP=0, RDATA=0, ctrl_o=0, wr_pulse_o=0. Both FSMs return to idle.
- The READY signals are registered. They rise on the first clk edge after rst_n deasserts. Ready-before-valid is normal operation.
- Write latency:
  - BVALID is high on the cycle after the final AW/W handshake.
  - ctrl_o shows the new value on that same cycle.
  - wr_pulse_o is high for exactly that one cycle.
- Read latency: RVALID is high on the cycle after the AR handshake.
- BVALID, BRESP, RVALID, RDATA and RRESP are held stable until BREADY or RREADY is sampled high. Both VALIDs drop the edge after their handshake.
- A new AW/W is accepted only once W_IDLE is re-entered. Write throughput is therefore at most one write per 2 cycles; reads behave the same way.
- rst_n asserted mid-transaction: transactions in flight are abandoned with no response. Registers return to 0.

## Structure
- Shared package axi_lite_pkg holds:
  - RESP_OKAY = 2'b00, RESP_SLVERR = 2'b10.
  - The wr_state_t and rd_state_t enums.
  - A byte-merge function (old, new, strb) -> merged word.
- Single module; no sub-module needed.

## Test plan
- Reset, then check idle state: all outputs at reset values. One cycle after release, AWREADY=WREADY=ARREADY=1.
- Write 0x0000_0004 <- 0xA5A5_1234 with WSTRB=4'hF, AW and W together, BREADY=1:
  - BVALID on the next cycle with BRESP=0.
  - ctrl_o word 1 = 0xA5A5_1234.
  - wr_pulse_o[1] high for one cycle.
  - A subsequent read of 0x4 returns the same data with RRESP=0.
- Partial write and channel ordering: W (data 0xFFFF_FFFF, WSTRB=4'b0010) arrives 3 cycles before AW to 0x4, on the register above.
  - WREADY drops after the W handshake.
  - The result is 0xA5A5_FF34.
- Write to an RO index (0x20) and to an out-of-range index (0x40):
  - Both return BRESP=2'b10 with no ctrl_o change.
  - Reading 0x20 with status_i word 0 = 0xCAFE_0001 returns 0xCAFE_0001 / OKAY.
  - Reading 0x40 returns 0 / SLVERR.
- Backpressure: hold BREADY=0 and RREADY=0 for 5 cycles.
  - BVALID, RVALID and the data stay stable.
  - AWREADY, WREADY and ARREADY stay 0 until the response handshakes.
- Reset mid-write: assert rst_n=0 after the AW handshake but before W. All outputs return to reset values and no register is written.
